spi_regfile: RTL
================

Name: spi_regfile

Overview:
Parametrised SPI slave register file; successor to the single-word SPI config receiver. It holds NUM_REGS addressable DATA_W-bit configuration registers (phase increment, gain, filter/mode settings, ...) and adds addressed writes, MISO readback, frame-length checking and per-register write strobes. It sits between the external SPI pins and the radio datapath and runs entirely in the CLK domain, with SPI pins oversampled.

Parameters:
NUM_REGS, 4, number of implemented registers (1..2^ADDR_W)
ADDR_W, 2, address field width in bits
DATA_W, 32, register width in bits
RESET_VALS, {64'h0, 32'h00000003, 32'h001312eb}, NUM_REGS*DATA_W bits; register i resets to slice [i*DATA_W +: DATA_W]

Ports:
CLK  in  1  system clock
RSTb  in  1  reset, synchronous, active-low
SCK  in  1  SPI clock, async, mode 0 (CPOL=0, CPHA=0)
CS  in  1  SPI chip select, async, active-low
MOSI  in  1  SPI data in, async
MISO  out  1  SPI data out, registered
MISO_OE  out  1  high while MISO is actively driven (read data phase)
regs_flat  out  NUM_REGS*DATA_W  all registers; reg i at [i*DATA_W +: DATA_W]
wr_strobe  out  NUM_REGS  one-CLK pulse on bit i when reg i is updated
frame_err  out  1  one-CLK pulse when a frame is rejected

Behaviour:
- Reset (RSTb=0 at a CLK edge): regs_flat=RESET_VALS; wr_strobe=0; frame_err=0; MISO=0; MISO_OE=0; state=IDLE; bit counter=0; all synchroniser flops=0. Reset mid-frame aborts the frame with no commit; the next frame is accepted only after a fresh CS falling edge.
- Sync: CS, SCK and MOSI each pass through 2 flops (_q, _qq); CS and SCK get a third flop (_qqq) for edge detect. Rise = qq&~qqq, fall = ~qq&qqq. SCK high and low times must each be >=3 CLK periods.
- Frame (MSB first): bit0 = R/W (1=read), then ADDR_W address bits, then DATA_W data bits. FRAME_LEN = 1+ADDR_W+DATA_W. MOSI_qq is sampled on detected SCK rise.
- States:
  - IDLE: on CS fall -> RX; clear shift register, bit counter and error flag.
  - RX: on SCK rise, shift MOSI_qq in and increment the bit counter. The counter saturates at FRAME_LEN+1. On CS rise -> DONE.
  - DONE (one cycle): evaluate the frame, then go to IDLE.
  - Unreachable encodings -> IDLE.
- Commit in DONE:
  - Write frame with count==FRAME_LEN and addr<NUM_REGS: reg[addr] <= data; wr_strobe[addr]=1 in the following cycle (same edge as the regs_flat update is visible).
  - Read frame with count==FRAME_LEN and addr<NUM_REGS: no register change, no strobe.
  - Any frame with count!=FRAME_LEN (short or long), or addr>=NUM_REGS: no register change; frame_err=1 for one cycle.
  - Total latency from CS rising at the pin to updated regs_flat: 4 CLK cycles max.
- Readback:
  - On the SCK rise that completes the address (count becomes 1+ADDR_W) with R/W=1, load tx <= reg[addr], or 0 if addr>=NUM_REGS, and set MISO_OE=1.
  - On each subsequent detected SCK fall in RX: MISO <= tx[DATA_W-1] and tx shifts left with zero fill. The master therefore samples MSB on the first data-phase SCK rise.
  - After DATA_W data bits have been shifted out, MISO=0.
  - MISO_OE and MISO clear to 0 on CS rise detect and in IDLE.
  - During a read frame the MOSI data bits are don't-care.
- CS fall while in DONE is not possible, since DONE lasts one cycle. A CS fall detected in IDLE on the same cycle DONE exits is taken on the next cycle because the edge persists through the flops. Glitches shorter than 1 CLK may be missed.
- SCK edges while in IDLE (CS high) are ignored.

Test Plan:
- Reset -> regs_flat = RESET_VALS: reg0=0x001312eb, reg1=0x3, reg2=reg3=0; MISO=0, MISO_OE=0, no strobes.
- Write frame R/W=0, addr=2, data=0xDEADBEEF (35 SCK cycles) -> reg2=0xDEADBEEF within 4 CLK of CS rise; wr_strobe=4'b0100 for exactly 1 cycle; other registers unchanged; frame_err stays 0.
- Read frame R/W=1, addr=0 after reset -> master captures 0x001312eb on the 32 data-phase SCK rises; MISO_OE high only during the data phase; regs unchanged; no strobe.
- Short frame (20 bits, write addr=1) and long frame (36 bits) -> reg1 remains 0x3; frame_err pulses once per frame; wr_strobe stays 0.
- NUM_REGS=3 build: write addr=3 -> frame_err pulse, no change. Read addr=3 -> MISO returns 0x00000000.
- Assert RSTb low mid-way through a write to reg0 (bit 20) and release, then send a full write of 0x12345678 to reg0 -> reg0 = 0x001312eb after reset, then 0x12345678 after the full frame; no spurious strobe.

Source files
------------

// File: rtl/spi_regfile.sv
// Oversampled SPI mode-0 slave register file: addressed writes, MISO readback, frame-length check.
// Latency: CS rise at the pin to regs_flat/wr_strobe update is 4 CLK; there is no backpressure.
module spi_regfile #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 32,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = {64'h0, 32'h00000003, 32'h001312eb}
) (
  input  logic                       CLK,
  input  logic                       RSTb,
  input  logic                       SCK,
  input  logic                       CS,
  input  logic                       MOSI,
  output logic                       MISO,
  output logic                       MISO_OE,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    DONE = 2'd2
  } state_t;

  logic cs_q, cs_qq, cs_qqq;
  logic sck_q, sck_qq, sck_qqq;
  logic mosi_q, mosi_qq;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]       sr_q, sr_d;
  logic [DATA_W-1:0]          tx_q, tx_d;
  logic                       miso_q, miso_d;
  logic                       oe_q, oe_d;
  logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]        strobe_q, strobe_d;
  logic                       err_q, err_d;

  logic                 cs_rise, cs_fall, sck_rise, sck_fall;
  logic [FRAME_LEN-1:0] sr_shift;
  logic [ADDR_W-1:0]    addr, rd_addr;
  logic [DATA_W-1:0]    wdata, rd_word;
  logic                 rw, addr_ok;

  assign cs_rise  =  cs_qq  & ~cs_qqq;
  assign cs_fall  = ~cs_qq  &  cs_qqq;
  assign sck_rise =  sck_qq & ~sck_qqq;
  assign sck_fall = ~sck_qq &  sck_qqq;

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      cs_q     <= 1'b0;
      cs_qq    <= 1'b0;
      cs_qqq   <= 1'b0;
      sck_q    <= 1'b0;
      sck_qq   <= 1'b0;
      sck_qqq  <= 1'b0;
      mosi_q   <= 1'b0;
      mosi_qq  <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      tx_q     <= '0;
      miso_q   <= 1'b0;
      oe_q     <= 1'b0;
      regs_q   <= RESET_VALS;
      strobe_q <= '0;
      err_q    <= 1'b0;
    end else begin
      cs_q     <= CS;
      cs_qq    <= cs_q;
      cs_qqq   <= cs_qq;
      sck_q    <= SCK;
      sck_qq   <= sck_q;
      sck_qqq  <= sck_qq;
      mosi_q   <= MOSI;
      mosi_qq  <= mosi_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      tx_q     <= tx_d;
      miso_q   <= miso_d;
      oe_q     <= oe_d;
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    tx_d     = tx_q;
    miso_d   = miso_q;
    oe_d     = oe_q;
    regs_d   = regs_q;
    strobe_d = '0;
    err_d    = 1'b0;

    rw       = sr_q[FRAME_LEN-1];
    addr     = sr_q[DATA_W +: ADDR_W];
    wdata    = sr_q[DATA_W-1:0];
    addr_ok  = int'(addr) < NUM_REGS;
    sr_shift = {sr_q[FRAME_LEN-2:0], mosi_qq};
    rd_addr  = sr_shift[ADDR_W-1:0];
    // Unimplemented addresses read back as zero.
    rd_word  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(rd_addr) == i) rd_word = regs_q[i*DATA_W +: DATA_W];
    end

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        oe_d   = 1'b0;
        if (cs_fall) begin
          state_d = RX;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      RX: begin
        if (sck_rise) begin
          sr_d = sr_shift;
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
          // Address just completed on a read: stage the word for the data phase.
          if (cnt_q == CNT_ADDR && sr_shift[ADDR_W]) begin
            tx_d = rd_word;
            oe_d = 1'b1;
          end
        end
        if (sck_fall && oe_q) begin
          miso_d = tx_q[DATA_W-1];
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end
        if (cs_rise) begin
          state_d = DONE;
          miso_d  = 1'b0;
          oe_d    = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (cnt_q == CNT_FULL && addr_ok) begin
          if (!rw) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (int'(addr) == i) begin
                regs_d[i*DATA_W +: DATA_W] = wdata;
                strobe_d[i]                = 1'b1;
              end
            end
          end
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MISO      = miso_q;
  assign MISO_OE   = oe_q;
  assign regs_flat = regs_q;
  assign wr_strobe = strobe_q;
  assign frame_err = err_q;

endmodule
